// File: rtl/sprite_mask_writer_if.sv
// Stream-in and BRAM write-port bundle for the sprite mask writer.
interface sprite_mask_writer_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              mask_bit;
    logic              mask_valid;
    logic              mask_ready;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_din;
    logic              bram_we;

    // Pixel source and BRAM observer side.
    modport master (
        output mask_bit,
        output mask_valid,
        input  mask_ready,
        input  bram_addr,
        input  bram_din,
        input  bram_we
    );

    // Writer side: consumes the stream, drives the BRAM write port.
    modport slave (
        input  mask_bit,
        input  mask_valid,
        output mask_ready,
        output bram_addr,
        output bram_din,
        output bram_we
    );
endinterface

// File: rtl/sprite_mask_writer.sv
// Writes one shape slot of the 1-bit sprite mask BRAM, either from a raster-ordered
// pixel stream or by zero-filling. Slot layout: shape*WIDTH*HEIGHT + y*WIDTH + x.
module sprite_mask_writer #(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned HEIGHT   = 128,
    parameter int unsigned NUM_IMGS = 4,
    localparam int unsigned ADDR_W  = $clog2(WIDTH * HEIGHT * NUM_IMGS),
    localparam int unsigned SHAPE_W = (NUM_IMGS > 1) ? $clog2(NUM_IMGS) : 1
) (
    input  logic               pixel_clk_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    input  logic               clear_in,
    input  logic               abort_in,
    input  logic [SHAPE_W-1:0] shape_in,
    sprite_mask_writer_if.slave bus,
    output logic               busy_out,
    output logic               done_out
);

    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] SlotSize = ADDR_W'(WIDTH * HEIGHT);

    typedef enum logic [1:0] {StIdle, StWrite, StClear, StDone} state_e;

    state_e state_q, state_d;

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              din_q, din_d;
    logic              we_q, we_d;
    logic              done_q, busy_q;

    logic              hs;
    logic              last_px;
    logic              step;
    logic [ADDR_W-1:0] base;

    // Slot base computed once at latch time; the counter carries it from then on.
    assign base    = ADDR_W'(shape_in) * SlotSize;
    assign last_px = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

    // Abort forces ready low so a coinciding pixel is dropped, not written.
    assign bus.mask_ready = (state_q == StWrite) && !abort_in;
    assign hs             = bus.mask_valid && bus.mask_ready;

    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign bus.bram_we   = we_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;

    // State register.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start wins over clear in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    state_d = StWrite;
                end else if (clear_in) begin
                    state_d = StClear;
                end
            end
            StWrite: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else if (hs && last_px) begin
                    state_d = StDone;
                end
            end
            StClear: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else if (last_px) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: one write per handshake (stream) or per cycle (clear).
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        din_d  = din_q;
        we_d   = 1'b0;
        step   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_in || clear_in) begin
                    x_d   = '0;
                    y_d   = '0;
                    cnt_d = base;
                end
            end
            StWrite: begin
                if (hs) begin
                    we_d   = 1'b1;
                    din_d  = bus.mask_bit;
                    addr_d = cnt_q;
                    step   = 1'b1;
                end
            end
            StClear: begin
                if (!abort_in) begin
                    we_d   = 1'b1;
                    din_d  = 1'b0;
                    addr_d = cnt_q;
                    step   = 1'b1;
                end
            end
            default: ;
        endcase
        if (step) begin
            // Hold on the last pixel so the counter never points into the next slot.
            if (!last_px) begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
            if (x_q == XW'(WIDTH - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Datapath and registered status outputs; done/busy follow the state by one cycle.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q    <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            din_q  <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            we_q   <= we_d;
            done_q <= (state_q == StDone);
            busy_q <= (state_q == StWrite) || (state_q == StClear);
        end
    end

endmodule

// File: tb/tb_sprite_mask_writer.sv
// Scoreboard bench: stimulus pushes expected BRAM writes / done events, monitor pops them.
module tb_sprite_mask_writer;
    localparam int unsigned W      = 4;
    localparam int unsigned H      = 2;
    localparam int unsigned N      = 4;
    localparam int unsigned AW     = $clog2(W * H * N);
    localparam int unsigned NPIX   = W * H;

    typedef struct packed {
        logic          is_done;
        logic [AW-1:0] addr;
        logic          din;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       start_in;
    logic       clear_in;
    logic       abort_in;
    logic [1:0] shape_in;
    logic       busy_out;
    logic       done_out;

    sprite_mask_writer_if #(.ADDR_W(AW)) bus ();

    sprite_mask_writer #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .NUM_IMGS(N)
    ) dut (
        .pixel_clk_in(clk),
        .rst_n_in    (rst_n),
        .start_in    (start_in),
        .clear_in    (clear_in),
        .abort_in    (abort_in),
        .shape_in    (shape_in),
        .bus         (bus),
        .busy_out    (busy_out),
        .done_out    (done_out)
    );

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  since_we = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: pixel i of slot s lives at s*W*H + i.
    function automatic void push_write(input int s, input int i, input logic d);
        ev_t e;
        e.is_done = 1'b0;
        e.addr    = AW'(s * NPIX + i);
        e.din     = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done();
        ev_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.din     = 1'b0;
        exp_q.push_back(e);
    endfunction

    // Monitor: every we or done cycle must match the head of the expectation queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            since_we++;
            if (bus.bram_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d din %0d, expected none",
                             bus.bram_addr, bus.bram_din);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_write", int'(e.is_done), 0);
                    check("write_addr", int'(bus.bram_addr), int'(e.addr));
                    check("write_din", int'(bus.bram_din), int'(e.din));
                    check("busy_during_write", int'(busy_out), 1);
                end
                since_we = 0;
            end
            if (done_out) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done 1, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_done", int'(e.is_done), 1);
                    check("done_latency", since_we, 1);
                    check("busy_at_done", int'(busy_out), 0);
                end
            end
        end
    end

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input bit st, input bit cl, input int s);
        start_in = st;
        clear_in = cl;
        shape_in = 2'(s);
        @(posedge clk);
        #1;
        start_in = 1'b0;
        clear_in = 1'b0;
    endtask

    // mode: 0 back-to-back, 1 one gap per pixel, 2 random gaps. noise pulses start/clear.
    task automatic do_stream(input int s, input logic [7:0] bits, input int mode,
                             input bit noise, input bit both);
        int ngap;
        issue_cmd(1'b1, both, s);
        @(negedge clk);
        check("ready_after_start", int'(bus.mask_ready), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < NPIX; i++) begin
            ngap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (ngap) begin
                bus.mask_valid = 1'b0;
                bus.mask_bit   = 1'($urandom);
                if (noise) begin
                    start_in = 1'($urandom);
                    clear_in = 1'($urandom);
                    shape_in = 2'($urandom);
                end
                @(posedge clk);
                #1;
            end
            start_in       = 1'b0;
            clear_in       = 1'b0;
            bus.mask_valid = 1'b1;
            bus.mask_bit   = bits[i];
            push_write(s, i, bits[i]);
            @(negedge clk);
            check("ready_in_write", int'(bus.mask_ready), 1);
            @(posedge clk);
            #1;
        end
        bus.mask_valid = 1'b0;
        push_done();
        drain();
    endtask

    task automatic do_clear(input int s);
        issue_cmd(1'b0, 1'b1, s);
        for (int i = 0; i < NPIX; i++) push_write(s, i, 1'b0);
        push_done();
        for (int c = 0; c < NPIX + 4; c++) begin
            bus.mask_valid = 1'($urandom);
            bus.mask_bit   = 1'($urandom);
            @(negedge clk);
            check("ready_in_clear", int'(bus.mask_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.mask_valid = 1'b0;
        drain();
    endtask

    task automatic do_abort_stream(input int s, input int npix);
        logic b;
        issue_cmd(1'b1, 1'b0, s);
        for (int i = 0; i < npix; i++) begin
            b = 1'($urandom);
            bus.mask_valid = 1'b1;
            bus.mask_bit   = b;
            push_write(s, i, b);
            @(posedge clk);
            #1;
        end
        bus.mask_bit = 1'b1;
        abort_in     = 1'b1;
        @(negedge clk);
        check("ready_on_abort", int'(bus.mask_ready), 0);
        @(posedge clk);
        #1;
        abort_in       = 1'b0;
        bus.mask_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_drain", exp_q.size(), 0);
        check("idle_after_abort_busy", int'(busy_out), 0);
    endtask

    task automatic do_abort_clear(input int s, input int nwr);
        issue_cmd(1'b0, 1'b1, s);
        for (int i = 0; i < nwr; i++) begin
            push_write(s, i, 1'b0);
            @(posedge clk);
            #1;
        end
        abort_in = 1'b1;
        @(posedge clk);
        #1;
        abort_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_clear_drain", exp_q.size(), 0);
    endtask

    task automatic do_reset_mid_write(input int s);
        logic b;
        issue_cmd(1'b1, 1'b0, s);
        for (int i = 0; i < 3; i++) begin
            b = 1'($urandom);
            bus.mask_valid = 1'b1;
            bus.mask_bit   = b;
            // The third write is cut off by the reset before the monitor samples it.
            if (i < 2) push_write(s, i, b);
            @(posedge clk);
            if (i < 2) #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_we", int'(bus.bram_we), 0);
        check("rst_async_din", int'(bus.bram_din), 0);
        check("rst_async_addr", int'(bus.bram_addr), 0);
        check("rst_async_busy", int'(busy_out), 0);
        check("rst_async_done", int'(done_out), 0);
        check("rst_async_ready", int'(bus.mask_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.mask_valid = 1'($urandom);
            bus.mask_bit   = 1'($urandom);
            @(negedge clk);
            check("ready_idle_after_reset", int'(bus.mask_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.mask_valid = 1'b0;
        check("reset_drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        rst_n          = 1'b1;
        start_in       = 1'b0;
        clear_in       = 1'b0;
        abort_in       = 1'b0;
        shape_in       = 2'd0;
        bus.mask_bit   = 1'b0;
        bus.mask_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        check("reset_we", int'(bus.bram_we), 0);
        check("reset_addr", int'(bus.bram_addr), 0);
        check("reset_din", int'(bus.bram_din), 0);
        check("reset_busy", int'(busy_out), 0);
        check("reset_done", int'(done_out), 0);
        check("reset_ready", int'(bus.mask_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_reset_mid_write(1);
        do_stream(2, 8'h4D, 0, 1'b0, 1'b0);
        do_stream(0, 8'($urandom), 1, 1'b0, 1'b0);
        do_clear(3);
        do_abort_stream(1, 5);
        do_stream(1, 8'($urandom), 0, 1'b0, 1'b0);
        do_abort_clear(2, 3);
        do_stream(int'($urandom_range(0, 3)), 8'($urandom), 2, 1'b1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: do_stream(int'($urandom_range(0, 3)), 8'($urandom), 2, 1'b1, 1'b0);
                1: do_clear(int'($urandom_range(0, 3)));
                2: do_abort_stream(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
                default: do_stream(int'($urandom_range(0, 3)), 8'($urandom), 0, 1'b0, 1'b1);
            endcase
        end

        repeat (4) @(posedge clk);
        check("final_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_mask_writer.md
Name: sprite_mask_writer

Overview:
Write-side counterpart to the transparent sprite mask reader. Accepts a raster-ordered stream of 1-bit mask pixels, or an internal clear request, for one selected shape slot. Drives the write port of the shared 1-bit shape-mask BRAM. Addresses follow the reader's layout: addr = shape*WIDTH*HEIGHT + y*WIDTH + x. Used to upload or refresh sprite masks at runtime, for example from a thresholded camera frame or a UART loader.

Parameters:
- WIDTH, 128: sprite width in pixels.
- HEIGHT, 128: sprite height in pixels.
- NUM_IMGS, 4: number of shape slots in the BRAM.
- ADDR_W, $clog2(WIDTH*HEIGHT*NUM_IMGS): BRAM address width (derived, not overridden).
- SHAPE_W, $clog2(NUM_IMGS): width of the shape select (minimum 1).

Ports:
- pixel_clk_in, input, 1: single clock for all logic.
- rst_n_in, input, 1: asynchronous active-low reset.
- start_in, input, 1: begin a stream upload into slot shape_in. Sampled in IDLE only.
- clear_in, input, 1: begin zero-filling slot shape_in. Sampled in IDLE only. start_in wins if both are asserted.
- abort_in, input, 1: terminate the current operation.
- shape_in, input, SHAPE_W: target slot; latched on start or clear.
- mask_bit_in, input, 1: stream pixel value (1 = draw).
- mask_valid_in, input, 1: stream pixel valid.
- mask_ready_out, output, 1: stream ready.
- bram_addr_out, output, ADDR_W: BRAM write address.
- bram_din_out, output, 1: BRAM write data.
- bram_we_out, output, 1: BRAM write enable.
- busy_out, output, 1: high in WRITE or CLEAR.
- done_out, output, 1: one-cycle pulse when a full slot has been written.

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0 and state goes to IDLE. Internal x/y counters, address counter and latched shape go to 0.
- Reset mid-operation: no further writes occur and no done_out pulse is issued. The slot contents are left partial, and this is acceptable.
- FSM states are IDLE, WRITE, CLEAR and DONE.
- IDLE:
  - start_in: latch shape, set base = shape*WIDTH*HEIGHT, set x = y = 0, go to WRITE.
  - Otherwise clear_in: same setup, go to CLEAR.
- WRITE:
  - mask_ready_out = 1 combinationally while in WRITE, and 0 in every other state.
  - A handshake occurs when mask_valid_in && mask_ready_out. On a handshake, on the next edge: bram_we_out = 1, bram_din_out = mask_bit_in, bram_addr_out = address counter. The address counter then increments.
  - Write latency is 1 cycle from handshake to we.
  - No handshake: bram_we_out = 0, and addr/din hold their last values.
  - x increments per handshake. When x = WIDTH-1, x wraps to 0 and y increments.
  - The handshake at (x = WIDTH-1, y = HEIGHT-1) moves to DONE.
- CLEAR:
  - One write per cycle with din = 0, no handshake. Same x/y/address sequencing and same last-pixel rule as WRITE.
  - Stream inputs are ignored.
- DONE: done_out = 1 for exactly one cycle, we = 0, then go to IDLE.
- abort_in in WRITE or CLEAR:
  - Go to IDLE next edge; no write in that cycle.
  - A handshake coinciding with abort is dropped, since ready is forced to 0 when abort_in = 1.
  - No done_out pulse.
  - abort_in in IDLE or DONE has no effect.
- start_in and clear_in are ignored outside IDLE. There is no queuing.
- Address arithmetic:
  - Use an incrementing counter, not a multiplier. The base is computed once at latch time, with the multiply by the constant WIDTH*HEIGHT done at ADDR_W width.
  - The last address written is base + WIDTH*HEIGHT - 1. The counter never crosses into the next slot.
- busy_out = 1 in WRITE or CLEAR.
- Outputs bram_*, done_out and busy_out are registered. mask_ready_out is combinational from state and abort_in.

Test Plan:
All scenarios use WIDTH=4, HEIGHT=2, NUM_IMGS=4.
1. Reset asserted mid-WRITE after 3 pixels: all outputs are 0 immediately (asynchronous). After release, no we and no done until a new start_in.
2. Stream upload: start_in with shape_in=2, then 8 back-to-back valid pixels with pattern 1,0,1,1,0,0,1,0:
   - we is high for 8 cycles at addrs 16..23 with matching din.
   - done_out pulses once, 1 cycle after the last write.
   - busy_out drops with it.
3. Backpressure and gaps: start_in with shape_in=0, valid toggling every other cycle:
   - Writes occur only on handshake cycles, addrs 0..7 in order.
   - Row wrap is correct at x=3 (addr 3 is followed by addr 4).
4. Clear: clear_in with shape_in=3:
   - 8 consecutive writes of din=0 at addrs 24..31. mask_ready_out stays 0 throughout.
   - done pulses once.
5. Abort: start_in with shape_in=1, 5 pixels written (addrs 8..12), then abort_in together with a valid pixel:
   - No write at 13 and no done_out.
   - Back in IDLE. A new start_in restarts at addr 8.
6. Ignored commands: start_in and clear_in pulsed during WRITE have no effect on the address sequence. Simultaneous start_in and clear_in in IDLE selects WRITE (mask_ready_out = 1).
